if_id_stage: RTL and testbench

- Fetch stage plus IF/ID pipeline register for the five-stage MIPS core.
- Owns the PC and produces the instruction-memory address.
- Latches the fetched word, its PC and PC+8 into the D stage.
- Splits the word into fields and pre-decodes the extension mode, so D-stage imm16 and ext_op drive the immediate extender directly.

---
 rtl/if_id_stage_pkg.sv | 32 +++
 rtl/if_id_stage_if.sv | 40 ++++
 rtl/if_id_stage_ext_predecode.sv | 19 +
 rtl/if_id_stage.sv | 76 +++++++
 tb/tb_if_id_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch stage and D-stage decode:
// reset defaults, MIPS opcodes and immediate-extension modes.
package if_id_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] LINK_OFFSET  = 32'd8;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_BNE   = 6'b000101;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_ADDIU = 6'b001001;
    localparam opcode_t OP_SLTI  = 6'b001010;
    localparam opcode_t OP_ANDI  = 6'b001100;
    localparam opcode_t OP_ORI   = 6'b001101;
    localparam opcode_t OP_XORI  = 6'b001110;
    localparam opcode_t OP_LUI   = 6'b001111;
    localparam opcode_t OP_LB    = 6'b100000;
    localparam opcode_t OP_LH    = 6'b100001;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SB    = 6'b101000;
    localparam opcode_t OP_SH    = 6'b101001;
    localparam opcode_t OP_SW    = 6'b101011;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: hazard controls, instruction-memory port and the
// IF/ID register outputs consumed by the D stage.
interface if_id_stage_if;

    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic [5:0]  op_d;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [4:0]  rd_d;
    logic [4:0]  shamt_d;
    logic [5:0]  funct_d;
    logic [15:0] imm16_d;
    logic [25:0] imm26_d;
    logic        ext_op_d;

    modport master (
        input  stall, flush, redirect, redirect_pc, im_rdata,
        output im_addr, pc_f, instr_d, pc_d, pc8_d, valid_d,
               op_d, rs_d, rt_d, rd_d, shamt_d, funct_d,
               imm16_d, imm26_d, ext_op_d
    );

    modport slave (
        output stall, flush, redirect, redirect_pc, im_rdata,
        input  im_addr, pc_f, instr_d, pc_d, pc8_d, valid_d,
               op_d, rs_d, rt_d, rd_d, shamt_d, funct_d,
               imm16_d, imm26_d, ext_op_d
    );

endinterface

// File: rtl/if_id_stage_ext_predecode.sv
// Opcode to immediate-extension mode; shared with the D-stage controller.
module if_id_stage_ext_predecode
    import if_id_stage_pkg::*;
(
    input  opcode_t op,
    output logic    ext_op
);

    // Loads, stores, branches and signed-arithmetic immediates sign-extend.
    always_comb begin
        ext_op = EXT_ZERO;
        case (op)
            OP_LW, OP_SW, OP_LB, OP_LH, OP_SB, OP_SH,
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI: ext_op = EXT_SIGN;
            default:                                     ext_op = EXT_ZERO;
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: owns the PC, reads instruction memory and fills the IF/ID
// register with the word, its PC, the link value and the extension mode.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
)(
    input  logic          clk,
    input  logic          reset,
    if_id_stage_if.master bus
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_d_q;
    logic [31:0] pc8_q;
    logic        valid_q;
    logic        ext_q;
    logic        ext_f;

    if_id_stage_ext_predecode u_ext_predecode (
        .op     (bus.im_rdata[31:26]),
        .ext_op (ext_f)
    );

    // Stall outranks redirect; the hazard unit re-issues a dropped redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (!bus.stall) begin
            if (bus.redirect) pc_q <= {bus.redirect_pc[31:2], 2'b00};
            else              pc_q <= pc_q + PC_STEP;
        end
    end

    // Redirect never squashes IF/ID: the delay-slot word is latched normally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_WORD;
            pc_d_q  <= RESET_PC;
            pc8_q   <= RESET_PC + LINK_OFFSET;
            valid_q <= 1'b0;
            ext_q   <= EXT_ZERO;
        end else if (bus.flush) begin
            instr_q <= NOP_WORD;
            pc_d_q  <= pc_q;
            pc8_q   <= pc_q + LINK_OFFSET;
            valid_q <= 1'b0;
            ext_q   <= EXT_ZERO;
        end else if (!bus.stall) begin
            instr_q <= bus.im_rdata;
            pc_d_q  <= pc_q;
            pc8_q   <= pc_q + LINK_OFFSET;
            valid_q <= 1'b1;
            ext_q   <= ext_f;
        end
    end

    assign bus.im_addr  = pc_q;
    assign bus.pc_f     = pc_q;
    assign bus.instr_d  = instr_q;
    assign bus.pc_d     = pc_d_q;
    assign bus.pc8_d    = pc8_q;
    assign bus.valid_d  = valid_q;
    assign bus.ext_op_d = ext_q;
    assign bus.op_d     = instr_q[31:26];
    assign bus.rs_d     = instr_q[25:21];
    assign bus.rt_d     = instr_q[20:16];
    assign bus.rd_d     = instr_q[15:11];
    assign bus.shamt_d  = instr_q[10:6];
    assign bus.funct_d  = instr_q[5:0];
    assign bus.imm16_d  = instr_q[15:0];
    assign bus.imm26_d  = instr_q[25:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios with literal expectations, then
// randomized hazard traffic compared every cycle against a behavioural model.
module tb_if_id_stage;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    bit   check_en;

    if_id_stage_if bus ();

    if_id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0000_3004: return 32'h3421_ABCD;
            32'h0000_3008: return 32'h8C22_FFFC;
            32'h0000_300C: return 32'h3C01_1234;
            default: begin
                h = a * 32'h9E37_79B1;
                h = h ^ (h >> 13) ^ 32'h5A5A_1357;
                return h * 32'h0001_0DCD;
            end
        endcase
    endfunction

    assign bus.im_rdata = mem_word(bus.im_addr);

    function automatic logic sign_ext(input logic [5:0] op);
        return op inside {6'o43, 6'o53, 6'o40, 6'o41, 6'o50, 6'o51,
                          6'o04, 6'o05, 6'o10, 6'o11, 6'o12};
    endfunction

    // Behavioural model of PC and the D-stage contents.
    logic [31:0] m_pc, m_instr, m_pc_d;
    logic        m_valid, m_ext;

    task automatic model_reset();
        m_pc    = 32'h3000;
        m_instr = 32'h0;
        m_pc_d  = 32'h3000;
        m_valid = 1'b0;
        m_ext   = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            if (bus.flush) begin
                m_instr = 32'h0; m_valid = 1'b0; m_ext = 1'b0; m_pc_d = m_pc;
            end else if (!bus.stall) begin
                m_instr = mem_word(m_pc);
                m_valid = 1'b1;
                m_ext   = sign_ext(m_instr[31:26]);
                m_pc_d  = m_pc;
            end
            if (!bus.stall)
                m_pc = bus.redirect ? (bus.redirect_pc & ~32'd3) : m_pc + 32'd4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_pc_f",    bus.pc_f,              m_pc);
            chk("m_im_addr", bus.im_addr,           m_pc);
            chk("m_instr",   bus.instr_d,           m_instr);
            chk("m_pc_d",    bus.pc_d,              m_pc_d);
            chk("m_pc8_d",   bus.pc8_d,             m_pc_d + 32'd8);
            chk("m_valid",   {31'd0, bus.valid_d},  {31'd0, m_valid});
            chk("m_ext",     {31'd0, bus.ext_op_d}, {31'd0, m_ext});
            chk("m_fields",  {bus.op_d, bus.rs_d, bus.rt_d, bus.rd_d, bus.shamt_d, bus.funct_d}, m_instr);
            chk("m_imm16",   {16'd0, bus.imm16_d},  {16'd0, m_instr[15:0]});
            chk("m_imm26",   {6'd0, bus.imm26_d},   {6'd0, m_instr[25:0]});
        end
    end

    task automatic cyc(input bit s, input bit f, input bit r, input logic [31:0] rp);
        bus.stall = s; bus.flush = f; bus.redirect = r; bus.redirect_pc = rp;
        @(posedge clk); #1;
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_pc_f",  bus.pc_f,             32'h3000);
        chk("rst_instr", bus.instr_d,          32'h0);
        chk("rst_valid", {31'd0, bus.valid_d}, 32'd0);
        chk("rst_pc8",   bus.pc8_d,            32'h3008);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0; check_en = 1'b0;
        reset = 1'b0;
        model_reset();
        bus.stall = 0; bus.flush = 0; bus.redirect = 0; bus.redirect_pc = 0;
        #2 check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        chk("fetch0", bus.im_addr, 32'h3000);
        cyc(0, 0, 0, 0);
        chk("fetch1", bus.im_addr, 32'h3004);
        chk("first_pc_d", bus.pc_d, 32'h3000);
        chk("first_valid", {31'd0, bus.valid_d}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("fetch2",    bus.im_addr, 32'h3008);
        chk("ori_instr", bus.instr_d, 32'h3421_ABCD);
        chk("ori_op",    {26'd0, bus.op_d}, 32'h0D);
        chk("ori_rs",    {27'd0, bus.rs_d}, 32'd1);
        chk("ori_rt",    {27'd0, bus.rt_d}, 32'd1);
        chk("ori_imm16", {16'd0, bus.imm16_d}, 32'hABCD);
        chk("ori_ext",   {31'd0, bus.ext_op_d}, 32'd0);
        chk("ori_pc_d",  bus.pc_d, 32'h3004);
        chk("ori_pc8",   bus.pc8_d, 32'h300C);
        cyc(0, 0, 0, 0);
        chk("lw_ext", {31'd0, bus.ext_op_d}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("pre_rst_pc", bus.pc_f, 32'h3010);
        chk("pre_rst_instr", bus.instr_d, 32'h3C01_1234);
        async_reset_pulse();

        chk("rel_fetch0", bus.im_addr, 32'h3000);
        cyc(0, 0, 0, 0);
        chk("rel_fetch1", bus.im_addr, 32'h3004);
        cyc(0, 0, 0, 0);
        chk("rel_fetch2", bus.im_addr, 32'h3008);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(0, 0, 1, 32'h3040);
        chk("redir_pc",    bus.pc_f, 32'h3040);
        chk("slot_pc_d",   bus.pc_d, 32'h3010);
        chk("slot_instr",  bus.instr_d, mem_word(32'h3010));
        chk("slot_valid",  {31'd0, bus.valid_d}, 32'd1);
        cyc(0, 0, 1, 32'h3043);
        chk("redir_align", bus.pc_f, 32'h3040);
        cyc(0, 0, 1, 32'h3020);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 32'h3100);
            chk("stall_pc",    bus.pc_f, 32'h3020);
            chk("stall_pc_d",  bus.pc_d, 32'h3040);
            chk("stall_instr", bus.instr_d, mem_word(32'h3040));
        end
        cyc(0, 0, 0, 0);
        chk("resume_pc",   bus.pc_f, 32'h3024);
        chk("resume_pc_d", bus.pc_d, 32'h3020);
        cyc(1, 1, 0, 0);
        chk("fs_instr", bus.instr_d, 32'h0);
        chk("fs_valid", {31'd0, bus.valid_d}, 32'd0);
        chk("fs_ext",   {31'd0, bus.ext_op_d}, 32'd0);
        chk("fs_pc",    bus.pc_f, 32'h3024);
        cyc(0, 1, 1, 32'h3100);
        chk("fr_instr", bus.instr_d, 32'h0);
        chk("fr_pc",    bus.pc_f, 32'h3100);
        cyc(0, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_tgt", bus.pc_f, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("wrap_pc",   bus.pc_f, 32'h0);
        chk("wrap_pc_d", bus.pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc8",  bus.pc8_d, 32'h4);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset_pulse();
            end else begin
                cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 15,
                    ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                : $urandom);
            end
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
